bitstat_scheduler: RTL and testbench
====================================

BITSTAT_SCHEDULER -- requirements
Module: bitstat_scheduler

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, operand bits scanned per cycle.
REQ-003 Parameter NREQ, default 2, number of requesters, range 2..8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  NREQ  per-requester request valid.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-008 req_op  input  NREQ x 2  opcode: 0 COUNTONES, 1 CLOG2, 2 ONEHOT, 3 ONEHOT0.
REQ-009 req_data  input  NREQ x WIDTH  unsigned operand.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  consumer accept.
REQ-012 rsp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_result  output  32  result, zero-extended; boolean ops return 0 or 1.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 In IDLE, req_ready SHALL be one-hot on the round-robin winner among asserted req_valid; it SHALL be all-zero in BUSY and DONE.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod NREQ; last_grant SHALL update only on an accepted handshake.
REQ-017 An accept (req_valid[i] & req_ready[i]) SHALL latch the op, the id and the operand, then move to BUSY.
REQ-018 For CLOG2, the latched operand SHALL be data-1; when data==0, the latched operand SHALL be 0.
REQ-019 BUSY SHALL last exactly WIDTH/CHUNK cycles, scanning chunk k in BUSY cycle k, LSB chunk first.
REQ-020 Each BUSY cycle SHALL update a ones accumulator (sum of popcounts) and a highest-set-bit register.
REQ-021 The accumulator SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap.
REQ-022 After the last chunk, the FSM SHALL enter DONE with rsp_valid=1.
REQ-023 First rsp_valid SHALL occur WIDTH/CHUNK+1 cycles after the accept edge (5 cycles with the defaults).
REQ-024 Results SHALL be:
  - COUNTONES = ones.
  - CLOG2 = 0 when the latched operand is 0, else msb_index+1.
  - ONEHOT = (ones==1).
  - ONEHOT0 = (ones<=1).
REQ-025 In DONE, rsp_valid, rsp_id and rsp_result SHALL hold stable until rsp_ready=1.
REQ-026 DONE with rsp_ready=1 SHALL return to IDLE; a new accept SHALL occur no earlier than the following cycle.
REQ-027 req_valid deasserted without a handshake SHALL have no effect; requester inputs SHALL be ignored outside IDLE.
REQ-028 An opcode change on an input during BUSY SHALL NOT affect the operation in flight.

Reset
REQ-029 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and SHALL clear accumulator, msb register and chunk counter.
REQ-030 Reset SHALL set last_grant = NREQ-1, so requester 0 has first priority.
REQ-031 During and after reset, rsp_valid=0, rsp_result=0 and rsp_id=0.
REQ-032 A reset asserted mid-BUSY or mid-DONE SHALL discard the operation with no response issued.

Structure
REQ-033 A shared package bitstat_pkg SHALL hold the opcode enum, the FSM state enum and the 32-bit result width constant.
REQ-034 A single sub-module, bitstat_chunk, SHALL be combinational: it takes a CHUNK-bit slice and returns the slice popcount and the highest-set-bit index plus a found flag.
REQ-035 Arbitration and the FSM SHALL reside in bitstat_scheduler.

Verification
REQ-036 Req0 COUNTONES 16'hF0F1, rsp_ready=1 -> rsp_valid 5 cycles after accept, rsp_result=9, rsp_id=0.
REQ-037 CLOG2 operands 0, 1, 2, 17, 16'hFFFF -> results 0, 0, 1, 5, 16.
REQ-038 ONEHOT and ONEHOT0 operands 0, 16'h0400, 16'h0401 -> ONEHOT 0,1,0; ONEHOT0 1,1,0.
REQ-039 Both requesters valid continuously for 4 ops -> grants alternate 0,1,0,1; req_ready is never two-hot.
REQ-040 rsp_ready held 0 for 10 cycles in DONE -> outputs stable and no new req_ready; release -> IDLE next cycle.
REQ-041 rst_n=0 in BUSY cycle 2 -> no rsp_valid; the next request is granted to requester 0 with a fresh accumulator.

Source files
------------

// File: rtl/bitstat_pkg.sv
// bitstat_pkg: shared types and constants for the bit-statistics scheduler.
//   op_e     - request opcode (COUNTONES, CLOG2, ONEHOT, ONEHOT0)
//   state_e  - scheduler FSM state
//   RESULT_W - width of the zero-extended response result
package bitstat_pkg;

    localparam int RESULT_W = 32;

    typedef enum logic [1:0] {
        OP_COUNTONES = 2'd0,
        OP_CLOG2     = 2'd1,
        OP_ONEHOT    = 2'd2,
        OP_ONEHOT0   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitstat_chunk.sv
// bitstat_chunk: combinational statistics for one CHUNK-bit operand slice.
//   slice - input slice, bit 0 is the least significant
//   pop   - number of set bits in the slice
//   msb   - index of the highest set bit within the slice (0 when none)
//   found - at least one bit of the slice is set
module bitstat_chunk
    import bitstat_pkg::*;
#(
    parameter int CHUNK = 4,
    parameter int CW    = $clog2(CHUNK + 1),
    parameter int IW    = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] slice,
    output logic [CW-1:0]    pop,
    output logic [IW-1:0]    msb,
    output logic             found
);

    always_comb begin
        pop   = '0;
        msb   = '0;
        found = 1'b0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < CHUNK; i++) begin
            if (slice[i]) begin
                pop   = pop + CW'(1);
                msb   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitstat_scheduler.sv
// bitstat_scheduler: round-robin arbiter in front of a chunk-serial
// bit-statistics engine.
//   clk, rst_n  - clock and synchronous active-low reset
//   req_valid   - per-requester request valid
//   req_ready   - per-requester accept (one-hot round-robin winner in IDLE)
//   req_op      - per-requester opcode (op_e encoding)
//   req_data    - per-requester unsigned operand
//   rsp_valid   - result valid, held with rsp_id/rsp_result until rsp_ready
//   rsp_ready   - consumer accept
//   rsp_id      - requester that owns the result
//   rsp_result  - zero-extended result (booleans are 0/1)
module bitstat_scheduler
    import bitstat_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int NREQ  = 2,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][1:0]        req_op,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [RESULT_W-1:0]         rsp_result
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACCW = $clog2(WIDTH + 1);
    localparam int MSBW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW   = $clog2(CHUNK + 1);
    localparam int IW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    state_e            state;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    id_q;
    op_e               op_q;
    logic [WIDTH-1:0]  data_q;   // shifted right one chunk per BUSY cycle
    logic [CNTW-1:0]   cnt;
    logic [ACCW-1:0]   ones_q;
    logic [MSBW-1:0]   msb_q;
    logic              any_q;

    // ---------------- round-robin arbitration ----------------
    logic [NREQ-1:0]   grant_oh;
    logic [IDW-1:0]    grant_idx;
    int                arb_idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        arb_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = (int'(last_grant) + 1 + k) % NREQ;
            if (grant_oh == '0 && req_valid[arb_idx]) begin
                grant_oh[arb_idx] = 1'b1;
                grant_idx         = IDW'(arb_idx);
            end
        end
    end

    assign req_ready = (state == ST_IDLE) ? grant_oh : '0;

    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    assign sel_op   = req_op[grant_idx];
    assign sel_data = req_data[grant_idx];

    // ---------------- chunk scan ----------------
    logic [CW-1:0] c_pop;
    logic [IW-1:0] c_msb;
    logic          c_found;

    bitstat_chunk #(.CHUNK(CHUNK)) u_chunk (
        .slice (data_q[CHUNK-1:0]),
        .pop   (c_pop),
        .msb   (c_msb),
        .found (c_found)
    );

    logic [ACCW-1:0]     ones_nxt;
    logic [MSBW-1:0]     msb_nxt;
    logic                any_nxt;
    logic [RESULT_W-1:0] result_nxt;

    always_comb begin
        ones_nxt = ones_q + ACCW'(c_pop);
        any_nxt  = any_q | c_found;
        // Chunks arrive LSB first, so any hit here outranks earlier ones.
        msb_nxt  = c_found ? MSBW'(int'(cnt) * CHUNK + int'(c_msb)) : msb_q;
        case (op_q)
            OP_COUNTONES: result_nxt = RESULT_W'(ones_nxt);
            OP_CLOG2:     result_nxt = any_nxt ? RESULT_W'(msb_nxt) + RESULT_W'(1) : '0;
            OP_ONEHOT:    result_nxt = RESULT_W'(ones_nxt == ACCW'(1));
            default:      result_nxt = RESULT_W'(ones_nxt <= ACCW'(1));
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= IDW'(NREQ - 1);
            id_q       <= '0;
            op_q       <= OP_COUNTONES;
            data_q     <= '0;
            cnt        <= '0;
            ones_q     <= '0;
            msb_q      <= '0;
            any_q      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_oh != '0) begin
                        last_grant <= grant_idx;
                        id_q       <= grant_idx;
                        op_q       <= op_e'(sel_op);
                        // CLOG2 reduces to "highest set bit of data-1, plus one".
                        data_q     <= (op_e'(sel_op) == OP_CLOG2 && sel_data != '0)
                                      ? sel_data - WIDTH'(1) : sel_data;
                        cnt        <= '0;
                        ones_q     <= '0;
                        msb_q      <= '0;
                        any_q      <= 1'b0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    ones_q <= ones_nxt;
                    msb_q  <= msb_nxt;
                    any_q  <= any_nxt;
                    data_q <= data_q >> CHUNK;
                    cnt    <= cnt + CNTW'(1);
                    if (cnt == CNTW'(NCH - 1)) begin
                        state      <= ST_DONE;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= id_q;
                        rsp_result <= result_nxt;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state      <= ST_IDLE;
                        rsp_valid  <= 1'b0;
                        rsp_id     <= '0;
                        rsp_result <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitstat_scheduler.sv
module tb_bitstat_scheduler;

    localparam int W    = 16;
    localparam int C    = 4;
    localparam int NREQ = 2;
    localparam int LAT  = W / C + 1;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][1:0]    req_op;
    logic [NREQ-1:0][W-1:0]  req_data;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [0:0]              rsp_id;
    logic [31:0]             rsp_result;

    int tests = 0;
    int fails = 0;

    bitstat_scheduler #(.WIDTH(W), .CHUNK(C), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // Reference: results straight from the arithmetic definitions.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [W-1:0] d);
        int ones;
        int c;
        ones = $countones(d);
        c    = 0;
        case (op)
            2'd0: return 32'(ones);
            2'd1: begin
                while ((longint'(1) << c) < longint'(d)) c++;
                return 32'(c);
            end
            2'd2: return 32'(ones == 1);
            default: return 32'(ones <= 1);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
    endtask

    // Issue one request from requester i alone; return result, id and the
    // number of cycles from the accept edge until rsp_valid is seen.
    task automatic run_op(input int i, input logic [1:0] op, input logic [W-1:0] d,
                          output logic [31:0] res, output int id, output int lat);
        int n;
        @(negedge clk);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_data[i]  = d;
        #1;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ready_onehot", 32'(req_ready), 32'(1) << i);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs while BUSY: the op in flight must not notice.
        req_valid   = '0;
        req_op[i]   = ~op;
        req_data[i] = ~d;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = rsp_result;
        id  = int'(rsp_id);
    endtask

    logic [31:0] res;
    int          id, lat, n, grants, exp_g;
    logic [31:0] hold_res;
    logic [0:0]  hold_id;
    logic [1:0]  rop;
    logic [W-1:0] rdat;
    int          ri;
    logic [W-1:0] clog_ops [5];
    logic [31:0]  clog_exp [5];
    logic [W-1:0] oh_ops   [3];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        clog_ops  = '{16'd0, 16'd1, 16'd2, 16'd17, 16'hFFFF};
        clog_exp  = '{32'd0, 32'd0, 32'd1, 32'd5, 32'd16};
        oh_ops    = '{16'h0000, 16'h0400, 16'h0401};

        reset_dut();

        // Single COUNTONES: latency, value and owner.
        run_op(0, 2'd0, 16'hF0F1, res, id, lat);
        check("cnt_latency", 32'(lat), 32'(LAT));
        check("cnt_result", res, 32'd9);
        check("cnt_id", 32'(id), 0);

        // CLOG2 boundaries, alternating requesters.
        for (int k = 0; k < 5; k++) begin
            run_op(k % 2, 2'd1, clog_ops[k], res, id, lat);
            check("clog2_result", res, clog_exp[k]);
            check("clog2_model", res, model(2'd1, clog_ops[k]));
            check("clog2_id", 32'(id), 32'(k % 2));
        end

        // ONEHOT / ONEHOT0.
        for (int k = 0; k < 3; k++) begin
            run_op(0, 2'd2, oh_ops[k], res, id, lat);
            check("onehot", res, (k == 1) ? 32'd1 : 32'd0);
            run_op(1, 2'd3, oh_ops[k], res, id, lat);
            check("onehot0", res, (k == 2) ? 32'd0 : 32'd1);
        end

        // Randomized ops against the reference model.
        for (int k = 0; k < 24; k++) begin
            ri  = int'($urandom_range(0, NREQ - 1));
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rdat = W'(1) << $urandom_range(0, W - 1);
                1:       rdat = W'($urandom_range(0, 3));
                default: rdat = W'($urandom);
            endcase
            run_op(ri, rop, rdat, res, id, lat);
            check("rand_result", res, model(rop, rdat));
            check("rand_id", 32'(id), 32'(ri));
            check("rand_latency", 32'(lat), 32'(LAT));
        end

        // Round robin with both requesters permanently valid.
        reset_dut();
        @(negedge clk);
        req_valid   = '1;
        req_op[0]   = 2'd0;
        req_data[0] = 16'h000F;
        req_op[1]   = 2'd0;
        req_data[1] = 16'h00FF;
        grants = 0;
        exp_g  = 0;
        n      = 0;
        #1;
        while (grants < 4 && n < 200) begin
            check("rr_not_twohot", 32'($countones(req_ready) <= 1), 1);
            if (req_ready != '0) begin
                check("rr_grant", 32'(req_ready), 32'(1) << exp_g);
                exp_g = (exp_g + 1) % NREQ;
                grants++;
            end
            @(negedge clk);
            #1;
            n++;
        end
        check("rr_grant_count", 32'(grants), 4);
        req_valid = '0;
        repeat (10) @(negedge clk);

        // Backpressure in DONE: outputs hold, no new grant, then release.
        rsp_ready = 1'b0;
        run_op(0, 2'd0, 16'h00F0, res, id, lat);
        check("bp_result", res, 32'd4);
        hold_res = rsp_result;
        hold_id  = rsp_id;
        req_valid[1] = 1'b1;
        req_op[1]    = 2'd0;
        req_data[1]  = 16'h0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("bp_valid_hold", 32'(rsp_valid), 1);
            check("bp_result_hold", rsp_result, hold_res);
            check("bp_id_hold", 32'(rsp_id), 32'(hold_id));
            check("bp_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_idle_ready", 32'(req_ready), 32'b10);
        check("bp_valid_drop", 32'(rsp_valid), 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_result", rsp_result, 32'd1);
        check("bp_next_id", 32'(rsp_id), 1);

        // Reset in BUSY cycle 2 discards the op and restores priority.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1]    = 2'd0;
        req_data[1]  = 16'hFFFF;
        #1;
        n = 0;
        while (!req_ready[1] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("rstbusy_no_rsp", 32'(rsp_valid), 0);
            check("rstbusy_result", rsp_result, 0);
            @(negedge clk);
        end
        req_valid   = '1;
        req_op[0]   = 2'd0;
        req_data[0] = 16'h0003;
        req_op[1]   = 2'd0;
        req_data[1] = 16'hFFFF;
        #1;
        check("rstbusy_prio", 32'(req_ready), 32'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rstbusy_latency", 32'(n), 32'(LAT));
        check("rstbusy_fresh_acc", rsp_result, 32'd2);
        check("rstbusy_id", 32'(rsp_id), 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
